nn_result_streamer: RTL

- Sits at the output side of the NN solver top. It is the reader and drainer for the solver's result outputs: the roots vector, the best error and the stop flag.
- On each rising edge of the stop flag, it snapshots the roots and the best error. It then streams them out as a framed word sequence over a valid/ready interface, followed by a status word holding the cycle count.
- A watchdog forces a frame marked as timed-out if training never stops.

---
 rtl/nn_result_streamer_if.sv | 30 +++
 rtl/nn_result_streamer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/nn_result_streamer_if.sv
// -----------------------------------------------------------------------------
// nn_result_streamer_if
// Valid/ready word stream carrying the solver result frame.
//   M_DATA  : W-bit stream word (master -> slave)
//   M_VALID : word valid (master -> slave)
//   M_LAST  : final word of the frame (master -> slave)
//   M_READY : downstream ready (slave -> master)
// -----------------------------------------------------------------------------
interface nn_result_streamer_if #(
    parameter int unsigned W = 34
) ();
    logic [W-1:0] M_DATA;
    logic         M_VALID;
    logic         M_READY;
    logic         M_LAST;

    modport master (
        output M_DATA,
        output M_VALID,
        output M_LAST,
        input  M_READY
    );

    modport slave (
        input  M_DATA,
        input  M_VALID,
        input  M_LAST,
        output M_READY
    );
endinterface

// File: rtl/nn_result_streamer.sv
// -----------------------------------------------------------------------------
// nn_result_streamer
// Captures the NN solver results on each rising edge of STOP_TRAINING (or on a
// watchdog expiry) and streams them as one frame:
//   root0 .. root(N-1), best error, status {timeout_flag, cycle_count}.
// Ports:
//   CLK           : clock, rising edge
//   RESET         : synchronous, active-low reset
//   STOP_TRAINING : solver done level, edge-detected here
//   ROOTS_IN      : N packed roots, root k at [(k+1)*W-1 : k*W]
//   BEST_ERROR_IN : solver best error
//   m_if          : master side of the result stream (M_DATA/M_VALID/M_LAST/M_READY)
//   BUSY          : high while a frame is being sent
//   FRAME_DONE    : one-cycle pulse after the last word is accepted
// -----------------------------------------------------------------------------
module nn_result_streamer #(
    parameter int unsigned BIT_WIDTH      = 32,
    parameter int unsigned EXTRA_BITS     = 2,
    parameter int unsigned NUM_UNKNOWNS   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                                              CLK,
    input  logic                                              RESET,
    input  logic                                              STOP_TRAINING,
    input  logic [NUM_UNKNOWNS*(BIT_WIDTH+EXTRA_BITS)-1:0]    ROOTS_IN,
    input  logic [BIT_WIDTH+EXTRA_BITS-1:0]                   BEST_ERROR_IN,
    nn_result_streamer_if.master                              m_if,
    output logic                                              BUSY,
    output logic                                              FRAME_DONE
);

    localparam int unsigned W     = BIT_WIDTH + EXTRA_BITS;
    localparam int unsigned IDX_W = $clog2(NUM_UNKNOWNS + 2);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UNKNOWNS + 1);
    localparam logic [IDX_W-1:0] BEST_IDX = IDX_W'(NUM_UNKNOWNS);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // The cycle count occupies the status word below the timeout flag.
    localparam logic [W-2:0] CNT_MAX     = {(W-1){1'b1}};
    localparam logic [W-2:0] CNT_ONE     = (W-1)'(1);
    localparam logic [W-2:0] TIMEOUT_VAL = (W-1)'(TIMEOUT_CYCLES);
    localparam bit           TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                      state_r,        state_nxt_s;
    logic [IDX_W-1:0]            idx_r,          idx_nxt_s;
    logic [W-2:0]                cnt_r,          cnt_nxt_s;
    logic                        stop_prev_r;
    logic [NUM_UNKNOWNS*W-1:0]   snap_roots_r,   snap_roots_nxt_s;
    logic [W-1:0]                snap_best_r,    snap_best_nxt_s;
    logic                        snap_tmo_r,     snap_tmo_nxt_s;
    logic [W-2:0]                snap_cnt_r,     snap_cnt_nxt_s;

    logic [W-1:0]                m_data_r,       m_data_nxt_s;
    logic                        m_valid_r,      m_valid_nxt_s;
    logic                        m_last_r,       m_last_nxt_s;
    logic                        busy_r,         busy_nxt_s;
    logic                        frame_done_r,   frame_done_nxt_s;

    logic                        rise_s;
    logic                        timeout_s;
    logic                        accept_s;

    // Selects frame word idx from a set of snapshot values.
    function automatic logic [W-1:0] frame_word(
        input logic [NUM_UNKNOWNS*W-1:0] roots,
        input logic [W-1:0]              best,
        input logic                      tmo,
        input logic [W-2:0]              cnt,
        input logic [IDX_W-1:0]          idx
    );
        logic [W-1:0] word;
        word = {tmo, cnt};
        if (idx < BEST_IDX) begin
            for (int k = 0; k < int'(NUM_UNKNOWNS); k++) begin
                word = (idx == IDX_W'(k)) ? roots[k*W +: W] : word;
            end
        end else if (idx == BEST_IDX) begin
            word = best;
        end else begin
            word = {tmo, cnt};
        end
        return word;
    endfunction

    assign rise_s    = STOP_TRAINING & ~stop_prev_r;
    assign timeout_s = TIMEOUT_EN && (cnt_r == TIMEOUT_VAL);
    // m_valid_r is the registered M_VALID, so acceptance never feeds back
    // combinationally into the stream outputs.
    assign accept_s  = m_valid_r & m_if.M_READY;

    // State register, snapshot registers and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r      <= ST_IDLE;
            idx_r        <= '0;
            cnt_r        <= '0;
            stop_prev_r  <= 1'b0;
            snap_roots_r <= '0;
            snap_best_r  <= '0;
            snap_tmo_r   <= 1'b0;
            snap_cnt_r   <= '0;
            m_data_r     <= '0;
            m_valid_r    <= 1'b0;
            m_last_r     <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            idx_r        <= idx_nxt_s;
            cnt_r        <= cnt_nxt_s;
            stop_prev_r  <= STOP_TRAINING;
            snap_roots_r <= snap_roots_nxt_s;
            snap_best_r  <= snap_best_nxt_s;
            snap_tmo_r   <= snap_tmo_nxt_s;
            snap_cnt_r   <= snap_cnt_nxt_s;
            m_data_r     <= m_data_nxt_s;
            m_valid_r    <= m_valid_nxt_s;
            m_last_r     <= m_last_nxt_s;
            busy_r       <= busy_nxt_s;
            frame_done_r <= frame_done_nxt_s;
        end
    end

    // Next-state, capture and next-output logic.
    always_comb begin
        state_nxt_s      = state_r;
        idx_nxt_s        = idx_r;
        cnt_nxt_s        = cnt_r;
        snap_roots_nxt_s = snap_roots_r;
        snap_best_nxt_s  = snap_best_r;
        snap_tmo_nxt_s   = snap_tmo_r;
        snap_cnt_nxt_s   = snap_cnt_r;
        m_data_nxt_s     = '0;
        m_valid_nxt_s    = 1'b0;
        m_last_nxt_s     = 1'b0;
        busy_nxt_s       = 1'b0;
        frame_done_nxt_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (rise_s || timeout_s) begin
                    // A genuine rise outranks the watchdog in the same cycle.
                    snap_roots_nxt_s = ROOTS_IN;
                    snap_best_nxt_s  = BEST_ERROR_IN;
                    snap_tmo_nxt_s   = ~rise_s;
                    snap_cnt_nxt_s   = cnt_r;
                    state_nxt_s      = ST_SEND;
                    idx_nxt_s        = '0;
                end else if (cnt_r != CNT_MAX) begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_SEND: begin
                if (accept_s) begin
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s = ST_DONE;
                        idx_nxt_s   = idx_r;
                    end else begin
                        idx_nxt_s = idx_r + IDX_ONE;
                    end
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
                idx_nxt_s   = '0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
                idx_nxt_s   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they appear registered
        // in the cycle the state is entered; words always come from the
        // (next) snapshot, never the live inputs.
        case (state_nxt_s)
            ST_SEND: begin
                m_valid_nxt_s = 1'b1;
                busy_nxt_s    = 1'b1;
                m_last_nxt_s  = (idx_nxt_s == LAST_IDX);
                m_data_nxt_s  = frame_word(snap_roots_nxt_s, snap_best_nxt_s,
                                           snap_tmo_nxt_s, snap_cnt_nxt_s, idx_nxt_s);
            end
            ST_DONE: begin
                frame_done_nxt_s = 1'b1;
            end
            default: begin
                frame_done_nxt_s = 1'b0;
            end
        endcase
    end

    assign m_if.M_DATA  = m_data_r;
    assign m_if.M_VALID = m_valid_r;
    assign m_if.M_LAST  = m_last_r;
    assign BUSY         = busy_r;
    assign FRAME_DONE   = frame_done_r;

endmodule
